ins_mem_loader: RTL and testbench
=================================

Name: ins_mem_loader

Overview:
Programming controller for the instruction memory. It accepts a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake and assembles little-endian instruction words. It writes those words sequentially from word address 0 and holds the processor stalled while loading. It also owns the instruction-memory address mux: the loader's write address is selected while loading, and the processor PC is passed through otherwise.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width in bits; must be a multiple of 8; BYTES = INSTRUCTION_WIDTH/8
MEMORY_DEPTH, 256, instruction memory depth in words; ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
PC_WIDTH, 32, width of the PC and of the memory byte address

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE
word_count  input  ADDRESS_WIDTH+1  number of words to load; sampled when start is accepted
byte_in  input  8  incoming data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
pc_address  input  PC_WIDTH  processor PC (byte address)
mem_address  output  PC_WIDTH  byte address to the instruction memory
mem_wr_en  output  1  instruction memory write strobe
mem_wr_data  output  INSTRUCTION_WIDTH  word to write
cpu_stall  output  1  holds the processor; high whenever state != IDLE
busy  output  1  same as cpu_stall
done  output  1  one-cycle pulse when the load completes

Behaviour:
- Reset: state=IDLE; byte counter, word index, assembly buffer and latched count cleared.
- Reset values: byte_ready=0, mem_wr_en=0, mem_wr_data=0, cpu_stall=0, busy=0, done=0, mem_address=pc_address.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - mem_address = pc_address (combinational pass-through); byte_ready=0.
  - On start: latch count = min(word_count, MEMORY_DEPTH) and clear word_idx and byte_cnt.
  - If count==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - Each cycle with byte_valid&&byte_ready, write byte_in into buffer[8*byte_cnt+7 : 8*byte_cnt] (byte 0 = LSB) and increment byte_cnt.
  - On acceptance of byte BYTES-1, reset byte_cnt to 0 and go to WRITE.
  - byte_valid low means stay; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0; mem_wr_en=1.
  - mem_address = zero-extended {word_idx, 2'b00}; mem_wr_data = buffer.
  - If word_idx == count-1, go to DONE; otherwise increment word_idx and return to COLLECT.
- DONE (one cycle): done=1, then go to IDLE. cpu_stall stays high during DONE and drops in the following IDLE cycle.
- Latency:
  - Write strobe is asserted the cycle after the last byte of a word is accepted.
  - Minimum cost per word is BYTES+1 cycles.
  - done follows the final write by one cycle.
- mem_address outside IDLE: always the loader address, including during COLLECT and DONE (mem_wr_en low there).
- mem_wr_data: valid only while mem_wr_en=1; holds the buffer value otherwise.
- start while not IDLE: ignored; no effect on count or progress.
- start coincident with rst: rst wins.
- word_count > MEMORY_DEPTH: clamped; exactly MEMORY_DEPTH words are written and the address never wraps.
- byte_valid in IDLE, WRITE or DONE: not accepted (ready=0); the source must hold it.
- rst mid-load: returns to IDLE immediately, partial word discarded, no done pulse. Words already written remain in memory.
- Load then rerun: a new start after done reloads from word 0.

Test Plan:
- Reset, then drive pc_address=0x0000_0010 -> mem_address=0x10, cpu_stall=0, byte_ready=0, done=0.
- start, word_count=2, bytes 13 05 10 00 93 05 20 00 back-to-back:
  - Writes 0x00100513 to addr 0x0 and 0x00200593 to addr 0x4, one cycle each.
  - done pulses once, 11 cycles after start.
  - cpu_stall high throughout, then low.
- Same load with byte_valid low for 3 cycles between bytes 2 and 3 -> identical written data. Write timing shifts by 3 cycles; no extra byte_ready acceptances.
- start with word_count=0 -> no mem_wr_en, done pulses the cycle after start. A second start pulse during COLLECT of a 1-word load is ignored.
- start with word_count=300 (MEMORY_DEPTH=256) and 1024 bytes fed -> last write at addr 0x3FC, done pulses, no write wraps to addr 0.
- Assert rst after 2 of 4 bytes of word 1 (word 0 written) -> IDLE next cycle, no further writes, no done. Then start with word_count=1 -> first write lands at addr 0x0.

Source files
------------

// File: rtl/ins_mem_loader.sv
// Instruction-memory programming controller.
// Assembles a little-endian byte stream into instruction words, writes them
// sequentially from word 0, stalls the processor while loading, and muxes the
// instruction-memory address between the loader and the processor PC.
module ins_mem_loader #(
  parameter  int INSTRUCTION_WIDTH = 32,
  parameter  int MEMORY_DEPTH      = 256,
  parameter  int PC_WIDTH          = 32,
  localparam int ADDRESS_WIDTH     = $clog2(MEMORY_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_WIDTH:0]       word_count,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  input  logic [PC_WIDTH-1:0]          pc_address,
  output logic [PC_WIDTH-1:0]          mem_address,
  output logic                         mem_wr_en,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wr_data,
  output logic                         cpu_stall,
  output logic                         busy,
  output logic                         done
);

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BSH   = $clog2(BYTES);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [BCW-1:0]         LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                       r_state;
  logic [BCW-1:0]               r_byte_cnt;
  logic [ADDRESS_WIDTH-1:0]     r_word_idx;
  logic [ADDRESS_WIDTH:0]       r_count;
  logic [INSTRUCTION_WIDTH-1:0] r_buf;

  logic [ADDRESS_WIDTH:0]       w_start_count;
  logic                         w_last_word;
  logic [PC_WIDTH-1:0]          w_ldr_addr;

  // Saturate a requested word count to the memory depth so the write
  // address can never wrap back over already-loaded words.
  function automatic logic [ADDRESS_WIDTH:0] clamp_count(input logic [ADDRESS_WIDTH:0] n);
    if (n > DEPTH_CNT) begin
      clamp_count = DEPTH_CNT;
    end else begin
      clamp_count = n;
    end
  endfunction

  assign w_start_count = clamp_count(word_count);
  assign w_last_word   = ({1'b0, r_word_idx} == (r_count - 1'b1));
  assign w_ldr_addr    = PC_WIDTH'(r_word_idx) << BSH;

  // Load sequencer: collect BYTES bytes, spend one cycle writing, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_count    <= '0;
      r_buf      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count    <= w_start_count;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_state    <= (w_start_count == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            r_buf[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt <= '0;
              r_state    <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_last_word) begin
            r_state <= S_DONE;
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are straight decodes of the registered state; the address mux
  // hands the memory back to the processor only while idle.
  always_comb begin
    byte_ready  = (r_state == S_COLLECT);
    mem_wr_en   = (r_state == S_WRITE);
    done        = (r_state == S_DONE);
    cpu_stall   = (r_state != S_IDLE);
    busy        = (r_state != S_IDLE);
    mem_wr_data = r_buf;
    mem_address = (r_state == S_IDLE) ? pc_address : w_ldr_addr;
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader: expected writes are queued as stimulus is planned
// and compared by a monitor whenever the loader strobes mem_wr_en.
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] pc_address;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        cpu_stall;
  logic        busy;
  logic        done;

  ins_mem_loader #(
    .INSTRUCTION_WIDTH(32),
    .MEMORY_DEPTH(256),
    .PC_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_count(word_count),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .pc_address(pc_address),
    .mem_address(mem_address),
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .cpu_stall(cpu_stall),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          stall_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  int          start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts handshakes, stall and done cycles; scoreboards writes.
  always @(negedge clk) begin
    wr_t e;
    if (byte_valid && byte_ready) acc_cnt++;
    if (cpu_stall) stall_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_wr_en) begin
      wr_cnt++;
      last_wr_addr = mem_address;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", mem_address, mem_wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (mem_address !== e.addr || mem_wr_data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   mem_address, mem_wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    word_count = wc;
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input int c);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 50) begin
      acc = byte_ready;
      tick();
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout byte=%h got no ready required ready", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input int base, input int maxc);
    int n;
    n = 0;
    while (done_cnt == base && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL done_timeout got no done required done within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    pc_address = 32'h0000_0010;
    repeat (3) tick();
    checks++;
    if (mem_address !== 32'h10) begin
      errors++;
      $display("FAIL reset_mem_address got %h required %h", mem_address, 32'h10);
    end
    checks++;
    if ({cpu_stall, busy, byte_ready, done, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_controls got %b required 00000", {cpu_stall, busy, byte_ready, done, mem_wr_en});
    end
    checks++;
    if (mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wr_data got %h required 0", mem_wr_data);
    end
    rst = 1'b0;
    tick();
    pc_address = 32'h0000_1234;
    #1;
    checks++;
    if (mem_address !== 32'h1234) begin
      errors++;
      $display("FAIL idle_pc_passthrough got %h required %h", mem_address, 32'h1234);
    end
    pc_address = 32'h0000_0010;
    tick();
  endtask

  task automatic run_two_words(input string nm, input int gap);
    int base, a0, s0, w0;
    base = done_cnt; a0 = acc_cnt; s0 = stall_cnt; w0 = wr_cnt;
    pulse_start(9'd2);
    push_exp(32'h0, 32'h0010_0513, start_cyc + 5 + gap);
    push_exp(32'h4, 32'h0020_0593, start_cyc + 10 + gap);
    checks++;
    if (mem_address !== 32'h0 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL %s_collect_addr got addr=%h stall=%b required addr=0 stall=1", nm, mem_address, cpu_stall);
    end
    send_byte(8'h13);
    send_byte(8'h05);
    repeat (gap) tick();
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h93);
    send_byte(8'h05);
    send_byte(8'h20);
    send_byte(8'h00);
    wait_done(base, 40);
    checks++;
    if (done_cyc != start_cyc + 11 + gap || done_cnt - base != 1) begin
      errors++;
      $display("FAIL %s_done got cyc=%0d pulses=%0d required cyc=%0d pulses=1",
               nm, done_cyc - start_cyc, done_cnt - base, 11 + gap);
    end
    checks++;
    if (acc_cnt - a0 != 8 || wr_cnt - w0 != 2) begin
      errors++;
      $display("FAIL %s_counts got accepts=%0d writes=%0d required 8 and 2", nm, acc_cnt - a0, wr_cnt - w0);
    end
    checks++;
    if (stall_cnt - s0 != 11 + gap || cpu_stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall got cycles=%0d now=%b required cycles=%0d now=0",
               nm, stall_cnt - s0, cpu_stall, 11 + gap);
    end
  endtask

  task automatic test_back_to_back();
    run_two_words("b2b", 0);
  endtask

  task automatic test_stalled_bytes();
    run_two_words("gap", 3);
  endtask

  task automatic test_zero_and_restart();
    int base, w0;
    base = done_cnt; w0 = wr_cnt;
    pulse_start(9'd0);
    checks++;
    if (done !== 1'b1 || cpu_stall !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b stall=%b wr=%b required 1 1 0", done, cpu_stall, mem_wr_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cpu_stall !== 1'b0 || wr_cnt != w0 || done_cnt - base != 1) begin
      errors++;
      $display("FAIL zero_after got done=%b stall=%b writes=%0d pulses=%0d required 0 0 0 1",
               done, cpu_stall, wr_cnt - w0, done_cnt - base);
    end
    base = done_cnt; w0 = wr_cnt;
    pulse_start(9'd1);
    push_exp(32'h0, 32'hA1B2_C3D4, -1);
    send_byte(8'hD4);
    send_byte(8'hC3);
    pulse_start(9'd5);
    send_byte(8'hB2);
    send_byte(8'hA1);
    wait_done(base, 40);
    repeat (8) tick();
    checks++;
    if (wr_cnt - w0 != 1 || done_cnt - base != 1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start got writes=%0d pulses=%0d stall=%b required 1 1 0",
               wr_cnt - w0, done_cnt - base, cpu_stall);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] words[256];
    int base, w0;
    base = done_cnt; w0 = wr_cnt;
    for (int i = 0; i < 256; i++) begin
      words[i] = $urandom;
      push_exp(32'(i) << 2, words[i], -1);
    end
    pulse_start(9'd300);
    for (int i = 0; i < 256; i++) send_word(words[i]);
    wait_done(base, 40);
    repeat (4) tick();
    checks++;
    if (wr_cnt - w0 != 256 || done_cnt - base != 1) begin
      errors++;
      $display("FAIL clamp_counts got writes=%0d pulses=%0d required 256 1", wr_cnt - w0, done_cnt - base);
    end
    checks++;
    if (last_wr_addr !== 32'h3FC) begin
      errors++;
      $display("FAIL clamp_last_addr got %h required %h", last_wr_addr, 32'h3FC);
    end
  endtask

  task automatic test_reset_midload();
    int base, w0;
    base = done_cnt; w0 = wr_cnt;
    pulse_start(9'd2);
    push_exp(32'h0, 32'h1122_3344, -1);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || mem_address !== 32'h10) begin
      errors++;
      $display("FAIL midreset_idle got stall=%b ready=%b addr=%h required 0 0 00000010",
               cpu_stall, byte_ready, mem_address);
    end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (wr_cnt - w0 != 1 || done_cnt != base) begin
      errors++;
      $display("FAIL midreset_effects got writes=%0d pulses=%0d required 1 0", wr_cnt - w0, done_cnt - base);
    end
    pulse_start(9'd1);
    push_exp(32'h0, 32'hCAFE_F00D, start_cyc + 5);
    send_word(32'hCAFE_F00D);
    wait_done(base, 40);
    checks++;
    if (wr_cnt - w0 != 2 || done_cnt - base != 1) begin
      errors++;
      $display("FAIL reload_counts got writes=%0d pulses=%0d required 2 1", wr_cnt - w0, done_cnt - base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stalled_bytes();
    test_zero_and_restart();
    test_clamp();
    test_reset_midload();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d outstanding required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
